// File: rtl/fir_coeff_loader.sv
// Coefficient sequencer in front of the adaptive FIR: forwards samples, collects a
// shadow buffer of taps from the config port and replays it with set_coeffs on commit.
module fir_coeff_loader #(
  parameter int NUM_TAPS = 3,
  parameter int DATA_W   = 8,
  parameter int DROP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              cfg_wvalid,
  output logic              cfg_wready,
  input  logic              cfg_commit,
  output logic              commit_err,
  output logic              busy,
  output logic [DATA_W-1:0] fir_x_n,
  output logic              fir_tvalid,
  output logic              fir_set_coeffs,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int PTR_W = $clog2(NUM_TAPS + 1);
  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  localparam logic [1:0] ST_STREAM = 2'd0;
  localparam logic [1:0] ST_GAP    = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_RESUME = 2'd3;

  localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(NUM_TAPS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_TAPS - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shadow_q [NUM_TAPS];
  logic [DATA_W-1:0] shadow_d [NUM_TAPS];

  logic [DATA_W-1:0] x_n_q, x_n_d;
  logic              tvalid_q, tvalid_d;
  logic              set_q, set_d;
  logic              err_q, err_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              drop_inc_s;
  logic              wr_en_s;

  assign cfg_wready     = (state_q == ST_STREAM) && (wptr_q < PTR_FULL);
  assign busy           = (state_q != ST_STREAM);
  assign wr_en_s        = cfg_wvalid && cfg_wready;
  assign commit_err     = err_q;
  assign fir_x_n        = x_n_q;
  assign fir_tvalid     = tvalid_q;
  assign fir_set_coeffs = set_q;
  assign drop_cnt       = drop_q;

  // FIR-side outputs are computed from the pre-edge state, so they lag the state by a cycle
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    x_n_d      = '0;
    tvalid_d   = 1'b0;
    set_d      = 1'b0;
    err_d      = 1'b0;
    drop_inc_s = 1'b0;
    case (state_q)
      ST_STREAM: begin
        if (cfg_commit && (wptr_q == PTR_FULL)) begin
          state_d    = ST_GAP;
          drop_inc_s = smp_valid;
        end else begin
          x_n_d    = smp_data;
          tvalid_d = smp_valid;
          err_d    = cfg_commit;
          if (wr_en_s) begin
            shadow_d[wptr_q[IDX_W-1:0]] = cfg_wdata;
            wptr_d = wptr_q + PTR_W'(1);
          end else begin
            wptr_d = wptr_q;
          end
        end
      end
      ST_GAP: begin
        state_d    = ST_LOAD;
        idx_d      = '0;
        drop_inc_s = smp_valid;
      end
      ST_LOAD: begin
        x_n_d      = shadow_q[idx_q];
        set_d      = 1'b1;
        drop_inc_s = smp_valid;
        if (idx_q == IDX_LAST) begin
          state_d = ST_RESUME;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_RESUME: begin
        state_d    = ST_STREAM;
        wptr_d     = '0;
        drop_inc_s = smp_valid;
      end
      default: begin
        state_d = ST_STREAM;
      end
    endcase

    if (drop_inc_s && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + DROP_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // State, shadow buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_STREAM;
      wptr_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '{default: '0};
      x_n_q    <= '0;
      tvalid_q <= 1'b0;
      set_q    <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      x_n_q    <= x_n_d;
      tvalid_q <= tvalid_d;
      set_q    <= set_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

endmodule
